// File: rtl/ooo_pkg.sv
// Shared types for the out-of-order front end: opcodes, op classes, the decoded
// instruction record and the pure decode function used at capture time.
package ooo_pkg;

   localparam int INSTR_W = 12;
   localparam int REG_W   = 3;
   localparam int SEQ_W   = 3;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_OR   = 3'b011,
      OP_XOR  = 3'b100,
      OP_LD   = 3'b101,
      OP_HALT = 3'b111
   } opcode_e;

   localparam logic [2:0] OP_ILLEGAL = 3'b110;

   typedef enum logic [1:0] {
      CLS_ALU  = 2'd0,
      CLS_LOAD = 2'd1,
      CLS_HALT = 2'd2
   } op_class_e;

   typedef struct packed {
      op_class_e         op_class;
      opcode_e           alu_op;
      logic [REG_W-1:0]  rd;
      logic [REG_W-1:0]  rs1;
      logic [REG_W-1:0]  rs2;
      logic              use_rs1;
      logic              use_rs2;
      logic [REG_W-1:0]  ld_addr;
      logic [SEQ_W-1:0]  tag;
   } decoded_instr_t;

   // Tag is left zero; the queue stamps it at push time.
   function automatic decoded_instr_t decode_instr(input logic [INSTR_W-1:0] w);
      decoded_instr_t d;
      d        = '0;
      d.alu_op = opcode_e'(w[11:9]);
      case (w[11:9])
         3'b000, 3'b001, 3'b010, 3'b011, 3'b100: begin
            d.op_class = CLS_ALU;
            d.rd       = w[8:6];
            d.rs1      = w[5:3];
            d.rs2      = w[2:0];
            d.use_rs1  = 1'b1;
            d.use_rs2  = 1'b1;
         end
         3'b101: begin
            // Loads carry an immediate address in the rs2 slot; no source regs read.
            d.op_class = CLS_LOAD;
            d.rd       = w[8:6];
            d.ld_addr  = w[2:0];
         end
         default: d.op_class = CLS_HALT;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/instr_decode_queue_if.sv
// Capture/issue bundle between the pin front end, the decode queue and the issue stage.
interface instr_decode_queue_if;
   import ooo_pkg::*;

   logic [INSTR_W-1:0] instr_in;
   logic               instr_valid;
   logic               dq_valid;
   logic               dq_ready;
   decoded_instr_t     dq_instr;
   logic               dq_halt;
   logic               q_full;
   logic               overflow;
   logic               illegal;

   modport master (
      output instr_in, instr_valid, dq_ready,
      input  dq_valid, dq_instr, dq_halt, q_full, overflow, illegal
   );

   modport slave (
      input  instr_in, instr_valid, dq_ready,
      output dq_valid, dq_instr, dq_halt, q_full, overflow, illegal
   );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a push into a full FIFO is accepted
// only when a pop happens on the same edge.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr, rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             wr_en, rd_en;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign wr_en = push & (~full | pop);
   assign rd_en = pop & ~empty;
   assign dout  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
         if (rd_en) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
   end

   // Storage needs no reset; validity is tracked by the pointers alone.
   always_ff @(posedge clock) begin
      if (wr_en && !reset) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/instr_decode_queue.sv
// Decodes incoming instruction words, stamps a wrapping age tag and buffers them
// in order for the issue stage; HALT closes the stream until reset.
module instr_decode_queue
   import ooo_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = SEQ_W
) (
   input  logic                 clock,
   input  logic                 reset,
   instr_decode_queue_if.slave  bus
);

   localparam int EW = $bits(decoded_instr_t);

   decoded_instr_t   dec, entry, head;
   logic [TAG_W-1:0] next_tag;
   logic             halted;
   logic             overflow_q, illegal_q;
   logic             live, is_illegal, push_req, push, pop;
   logic             empty, full;

   assign live       = bus.instr_valid & ~halted;
   assign is_illegal = (bus.instr_in[11:9] == OP_ILLEGAL);
   assign push_req   = live & ~is_illegal;
   assign pop        = ~empty & bus.dq_ready;
   assign push       = push_req & (~full | pop);

   always_comb begin
      dec       = decode_instr(bus.instr_in);
      entry     = dec;
      entry.tag = SEQ_W'(next_tag);
   end

   sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (entry),
      .dout  (head),
      .empty (empty),
      .full  (full)
   );

   // A word dropped on full consumes no tag and cannot raise halted.
   always_ff @(posedge clock) begin
      if (reset) begin
         next_tag   <= '0;
         halted     <= 1'b0;
         overflow_q <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         if (push) next_tag <= next_tag + TAG_W'(1);
         if (push && dec.op_class == CLS_HALT) halted <= 1'b1;
         if (push_req && full && !pop) overflow_q <= 1'b1;
         if (live && is_illegal) illegal_q <= 1'b1;
      end
   end

   assign bus.dq_valid = ~empty;
   assign bus.dq_instr = head;
   assign bus.dq_halt  = ~empty && (head.op_class == CLS_HALT);
   assign bus.q_full   = full;
   assign bus.overflow = overflow_q;
   assign bus.illegal  = illegal_q;

endmodule

// File: tb/tb_instr_decode_queue.sv
// Directed bench: stimulus pushes hand-computed decoded entries into a scoreboard,
// a negedge monitor pops and compares on every issue handshake.
module tb_instr_decode_queue;
   import ooo_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   decoded_instr_t exp_q[$];
   decoded_instr_t mon_e;

   instr_decode_queue_if bus();

   instr_decode_queue #(.DEPTH(4), .TAG_W(3)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "timeout");
   end

   function automatic decoded_instr_t mk(input op_class_e c, input opcode_e a,
                                          input int rd, input int rs1, input int rs2,
                                          input int u1, input int u2, input int la, input int tag);
      decoded_instr_t d;
      d.op_class = c;
      d.alu_op   = a;
      d.rd       = 3'(rd);
      d.rs1      = 3'(rs1);
      d.rs2      = 3'(rs2);
      d.use_rs1  = 1'(u1);
      d.use_rs2  = 1'(u2);
      d.ld_addr  = 3'(la);
      d.tag      = SEQ_W'(tag);
      return d;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Monitor: a handshake this cycle means the head leaves on the next edge.
   always @(negedge clock) begin
      if (!reset && bus.dq_valid === 1'b1 && bus.dq_ready === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pop actual=%h required=none", bus.dq_instr);
         end else begin
            mon_e = exp_q.pop_front();
            if (bus.dq_instr !== mon_e || bus.dq_halt !== (mon_e.op_class == CLS_HALT)) begin
               errors++;
               $display("FAIL pop_entry actual=%h/halt%b required=%h", bus.dq_instr, bus.dq_halt, mon_e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic [11:0] w);
      bus.instr_in    = w;
      bus.instr_valid = 1'b1;
      tick();
      bus.instr_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic drain();
      bus.dq_ready = 1'b1;
      for (int i = 0; i < 20 && bus.dq_valid; i++) tick();
      bus.dq_ready = 1'b0;
      chk("drain_valid", 32'(bus.dq_valid), 0);
      chk("drain_scoreboard", exp_q.size(), 0);
   endtask

   initial begin
      bus.instr_in    = '0;
      bus.instr_valid = 1'b0;
      bus.dq_ready    = 1'b0;
      reset           = 1'b1;
      repeat (2) tick();
      reset = 1'b0;

      chk("rst_dq_valid", 32'(bus.dq_valid), 0);
      chk("rst_dq_halt",  32'(bus.dq_halt),  0);
      chk("rst_q_full",   32'(bus.q_full),   0);
      chk("rst_overflow", 32'(bus.overflow), 0);
      chk("rst_illegal",  32'(bus.illegal),  0);

      // 1: in-order stream with the issue stage always ready
      bus.dq_ready = 1'b1;
      exp_q.push_back(mk(CLS_LOAD, OP_LD,  0, 0, 0, 0, 0, 0, 0)); send(12'b101_000_000_000);
      exp_q.push_back(mk(CLS_ALU,  OP_ADD, 1, 0, 2, 1, 1, 0, 1)); send(12'b000_001_000_010);
      exp_q.push_back(mk(CLS_ALU,  OP_SUB, 4, 5, 3, 1, 1, 0, 2)); send(12'b001_100_101_011);
      exp_q.push_back(mk(CLS_ALU,  OP_OR,  4, 6, 7, 1, 1, 0, 3)); send(12'b011_100_110_111);
      drain();
      chk("t1_overflow", 32'(bus.overflow), 0);
      chk("t1_illegal",  32'(bus.illegal),  0);

      // 2: fill with issue stalled, fifth word dropped
      do_reset();
      exp_q.push_back(mk(CLS_ALU,  OP_AND, 1, 2, 3, 1, 1, 0, 0)); send(12'b010_001_010_011);
      exp_q.push_back(mk(CLS_ALU,  OP_ADD, 2, 3, 4, 1, 1, 0, 1)); send(12'b000_010_011_100);
      exp_q.push_back(mk(CLS_ALU,  OP_XOR, 5, 6, 7, 1, 1, 0, 2)); send(12'b100_101_110_111);
      chk("t2_not_full_3", 32'(bus.q_full), 0);
      exp_q.push_back(mk(CLS_LOAD, OP_LD,  3, 0, 0, 0, 0, 5, 3)); send(12'b101_011_000_101);
      chk("t2_full_4",     32'(bus.q_full),   1);
      chk("t2_no_ovf_4",   32'(bus.overflow), 0);
      send(12'b001_111_111_111);
      chk("t2_full_5",     32'(bus.q_full),   1);
      chk("t2_ovf_5",      32'(bus.overflow), 1);
      drain();
      exp_q.push_back(mk(CLS_ALU, OP_OR, 1, 1, 1, 1, 1, 0, 4)); send(12'b011_001_001_001);
      drain();

      // 3: full queue, push and pop on the same edge
      do_reset();
      exp_q.push_back(mk(CLS_ALU,  OP_AND, 1, 2, 3, 1, 1, 0, 0)); send(12'b010_001_010_011);
      exp_q.push_back(mk(CLS_ALU,  OP_ADD, 2, 3, 4, 1, 1, 0, 1)); send(12'b000_010_011_100);
      exp_q.push_back(mk(CLS_ALU,  OP_XOR, 5, 6, 7, 1, 1, 0, 2)); send(12'b100_101_110_111);
      exp_q.push_back(mk(CLS_LOAD, OP_LD,  3, 0, 0, 0, 0, 5, 3)); send(12'b101_011_000_101);
      exp_q.push_back(mk(CLS_ALU,  OP_OR,  2, 2, 2, 1, 1, 0, 4));
      bus.dq_ready = 1'b1;
      send(12'b011_010_010_010);
      bus.dq_ready = 1'b0;
      chk("t3_full",  32'(bus.q_full),   1);
      chk("t3_noovf", 32'(bus.overflow), 0);
      drain();

      // 4: HALT closes the stream
      do_reset();
      exp_q.push_back(mk(CLS_ALU,  OP_XOR,  2, 3, 6, 1, 1, 0, 0)); send(12'b100_010_011_110);
      exp_q.push_back(mk(CLS_HALT, OP_HALT, 0, 0, 0, 0, 0, 0, 1)); send(12'b111_000_000_000);
      send(12'b010_011_111_110);
      chk("t4_head_not_halt", 32'(bus.dq_halt),  0);
      chk("t4_head_valid",    32'(bus.dq_valid), 1);
      bus.dq_ready = 1'b1; tick(); bus.dq_ready = 1'b0;
      chk("t4_halt_at_head",  32'(bus.dq_halt),  1);
      chk("t4_halt_valid",    32'(bus.dq_valid), 1);
      bus.dq_ready = 1'b1; tick(); bus.dq_ready = 1'b0;
      chk("t4_empty_after",   32'(bus.dq_valid), 0);
      send(12'b000_001_001_001);
      send(12'b110_000_000_000);
      repeat (3) tick();
      chk("t4_still_empty",   32'(bus.dq_valid), 0);
      chk("t4_no_ovf",        32'(bus.overflow), 0);
      chk("t4_no_illegal",    32'(bus.illegal),  0);
      chk("t4_scoreboard",    exp_q.size(),      0);

      // 5: illegal opcode is flagged and consumes nothing
      do_reset();
      send(12'b110_000_000_000);
      chk("t5_illegal",  32'(bus.illegal),  1);
      chk("t5_no_entry", 32'(bus.dq_valid), 0);
      exp_q.push_back(mk(CLS_ALU, OP_ADD, 7, 1, 2, 1, 1, 0, 0)); send(12'b000_111_001_010);
      chk("t5_entry", 32'(bus.dq_valid), 1);
      drain();

      // 6: reset mid-stream, then tag wrap
      do_reset();
      send(12'b110_000_000_000);
      send(12'b000_001_001_001);
      send(12'b000_010_010_010);
      send(12'b000_011_011_011);
      bus.instr_in    = 12'b000_100_100_100;
      bus.instr_valid = 1'b1;
      reset           = 1'b1;
      tick();
      reset           = 1'b0;
      bus.instr_valid = 1'b0;
      exp_q.delete();
      chk("t6_valid",    32'(bus.dq_valid), 0);
      chk("t6_full",     32'(bus.q_full),   0);
      chk("t6_overflow", 32'(bus.overflow), 0);
      chk("t6_illegal",  32'(bus.illegal),  0);
      bus.dq_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         exp_q.push_back(mk(CLS_ALU, OP_ADD, i % 8, 1, 2, 1, 1, 0, i % 8));
         send({3'b000, 3'(i % 8), 3'b001, 3'b010});
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
